// File: rtl/lr_pkg.sv
// Shared constants for the linear-regression datapaths.
// Covers the Q-format, the saturation limits and the requester indices.
package lr_pkg;

    localparam int DW   = 32;
    localparam int FRAC = 16;

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    localparam int REQ_THETA0 = 0;
    localparam int REQ_THETA1 = 1;

endpackage

// File: rtl/mul_pipe.sv
// Signed fixed-point multiply, round and saturate over MUL_LAT register stages.
// A one-hot tag shift register runs in parallel with the datapath.
module mul_pipe
    import lr_pkg::*;
#(
    parameter int DW      = lr_pkg::DW,
    parameter int FRAC    = lr_pkg::FRAC,
    parameter int N_REQ   = 2,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [N_REQ-1:0] in_tag,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic [N_REQ-1:0] out_tag,
    output logic [DW-1:0]    out_data,
    output logic             out_sat,
    output logic             busy
);

    localparam int PW = 2 * DW;
    localparam logic [PW-1:0]        RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [PW-1:0] HI  = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] LO  = ~HI;

    // Round half up, drop FRAC bits, then clamp into the DW-bit signed range.
    function automatic logic [DW:0] round_sat(input logic [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = $signed(p + RND) >>> FRAC;
        if (s > HI) begin
            round_sat = {1'b1, 1'b0, {(DW-1){1'b1}}};
        end else if (s < LO) begin
            round_sat = {1'b1, 1'b1, {(DW-1){1'b0}}};
        end else begin
            round_sat = {1'b0, s[DW-1:0]};
        end
    endfunction

    logic [PW-1:0]    prod_s;
    logic [N_REQ-1:0] tag_r [MUL_LAT];
    logic [DW:0]      res_r;

    // Sign-extended operands give the exact two's complement product in PW bits.
    assign prod_s = {{DW{in_a[DW-1]}}, in_a} * {{DW{in_b[DW-1]}}, in_b};

    // Tag shift register; flush and reset both drop every in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) tag_r[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < MUL_LAT; i++) tag_r[i] <= '0;
        end else begin
            tag_r[0] <= in_valid ? in_tag : '0;
            for (int i = 1; i < MUL_LAT; i++) tag_r[i] <= tag_r[i-1];
        end
    end

    generate
        if (MUL_LAT == 1) begin : g_one
            // Single stage: multiply, round and saturate in one cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) res_r <= '0;
                else     res_r <= round_sat(prod_s);
            end
        end else begin : g_multi
            logic [PW-1:0] prod_r [MUL_LAT-1];
            // Product delay line; the output stage rounds and saturates.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) prod_r[i] <= '0;
                    res_r <= '0;
                end else begin
                    prod_r[0] <= prod_s;
                    for (int i = 1; i < MUL_LAT - 1; i++) prod_r[i] <= prod_r[i-1];
                    res_r <= round_sat(prod_r[MUL_LAT-2]);
                end
            end
        end
    endgenerate

    // Any live tag in any stage means work is in flight.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) busy = busy | (|tag_r[i]);
    end

    assign out_tag  = tag_r[MUL_LAT-1];
    assign out_data = res_r[DW-1:0];
    assign out_sat  = res_r[DW];

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter that feeds requester operand pairs into one shared
// fixed-point multiplier pipeline and returns tagged results.
module mul_share_arb
    import lr_pkg::*;
#(
    parameter int DW      = lr_pkg::DW,
    parameter int FRAC    = lr_pkg::FRAC,
    parameter int N_REQ   = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_sat,
    output logic                busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    gidx_s;
    logic [PW:0]      idx_s;
    logic [N_REQ-1:0] grant_s;
    logic             xfer_s;
    logic [DW-1:0]    a_sel_s;
    logic [DW-1:0]    b_sel_s;

    // Scan from the largest offset down so the nearest valid requester wins.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        idx_s   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_s = {1'b0, ptr_r} + (PW+1)'(k);
            if (idx_s >= (PW+1)'(N_REQ)) begin
                idx_s = idx_s - (PW+1)'(N_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (req_valid[idx_s[PW-1:0]]) begin
                grant_s                    = '0;
                grant_s[idx_s[PW-1:0]]     = 1'b1;
                gidx_s                     = idx_s[PW-1:0];
            end else begin
                grant_s = grant_s;
                gidx_s  = gidx_s;
            end
        end
    end

    assign req_ready = (rst | flush) ? '0 : grant_s;
    assign xfer_s    = |req_ready;
    assign a_sel_s   = req_a[int'(gidx_s)*DW +: DW];
    assign b_sel_s   = req_b[int'(gidx_s)*DW +: DW];

    // Priority pointer moves just past the requester that was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (xfer_s) begin
            ptr_r <= (gidx_s == PW'(N_REQ - 1)) ? '0 : gidx_s + PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    mul_pipe #(
        .DW      (DW),
        .FRAC    (FRAC),
        .N_REQ   (N_REQ),
        .MUL_LAT (MUL_LAT)
    ) u_mul_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (xfer_s),
        .in_tag   (req_ready),
        .in_a     (a_sel_s),
        .in_b     (b_sel_s),
        .out_tag  (rsp_valid),
        .out_data (rsp_data),
        .out_sat  (rsp_sat),
        .busy     (busy)
    );

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: a queue-based reference model of
// round-robin grants and rounded/saturated products, plus literal spot checks.
module tb_mul_share_arb;

    localparam int N   = 2;
    localparam int LAT = 3;
    localparam int DW  = 32;

    typedef struct {
        int          due;
        logic [N-1:0] tag;
        logic [31:0] data;
        logic        sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_sat;
    logic            busy;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   mptr = 0;
    exp_t mq[$];
    logic        pend_v [N];
    logic [31:0] pend_a [N];
    logic [31:0] pend_b [N];

    mul_share_arb #(.DW(DW), .FRAC(16), .N_REQ(N), .MUL_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_sat   (rsp_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Real-number rule: product * 2^-16, rounded half up, clamped to int32.
    function automatic logic [32:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = (p + 64'sd32768) >>> 16;
        if (q > 64'sd2147483647)       return {1'b1, 32'h7FFFFFFF};
        else if (q < -64'sd2147483648) return {1'b1, 32'h80000000};
        else                           return {1'b0, q[31:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom();
        case ($urandom_range(0, 3))
            0:       return v;
            1:       return {{12{v[19]}}, v[19:0]};
            2:       return {{20{v[11]}}, v[11:0]};
            default: begin
                case (v[1:0])
                    2'd0:    return 32'h7FFFFFFF;
                    2'd1:    return 32'h80000000;
                    2'd2:    return 32'hFFFFFFFF;
                    default: return 32'h00000001;
                endcase
            end
        endcase
    endfunction

    // One clock cycle: check outputs against the model, drive, check grant.
    task automatic step(input logic fl);
        exp_t        e;
        int          g;
        logic [N-1:0] er;
        logic [32:0] m;
        @(negedge clk);
        cyc++;
        chk("busy", 64'(busy), 64'(mq.size() > 0));
        if (mq.size() > 0 && mq[0].due == cyc) begin
            e = mq.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(e.tag));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_sat", 64'(rsp_sat), 64'(e.sat));
        end else begin
            chk("rsp_idle", 64'(rsp_valid), 64'(0));
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = pend_v[i];
            req_a[i*DW +: DW]    = pend_a[i];
            req_b[i*DW +: DW]    = pend_b[i];
        end
        flush = fl;
        #1;
        g  = -1;
        er = '0;
        if (!fl) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend_v[(mptr + k) % N]) g = (mptr + k) % N;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        if (g >= 0) begin
            m      = model_mul(pend_a[g], pend_b[g]);
            e.due  = cyc + LAT;
            e.tag  = er;
            e.data = m[31:0];
            e.sat  = m[32];
            mq.push_back(e);
            mptr      = (g + 1) % N;
            pend_v[g] = 1'b0;
        end
        if (fl) mq.delete();
    endtask

    task automatic single(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic es);
        logic [N-1:0] et;
        chk("model_pin", 64'(model_mul(a, b)), 64'({es, ed}));
        pend_v[r] = 1'b1;
        pend_a[r] = a;
        pend_b[r] = b;
        step(1'b0);
        repeat (LAT) step(1'b0);
        et    = '0;
        et[r] = 1'b1;
        chk("lit_rsp_valid", 64'(rsp_valid), 64'(et));
        chk("lit_rsp_data", 64'(rsp_data), 64'(ed));
        chk("lit_rsp_sat", 64'(rsp_sat), 64'(es));
    endtask

    task automatic refill(input bit all_on);
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && (all_on || $urandom_range(0, 3) != 0)) begin
                pend_v[i] = 1'b1;
                pend_a[i] = rnd_op();
                pend_b[i] = rnd_op();
            end else if (pend_v[i] && !all_on && $urandom_range(0, 15) == 0) begin
                pend_v[i] = 1'b0;
            end else begin
                pend_v[i] = pend_v[i];
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst       = 1'b1;
        req_valid = '1;
        flush     = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_sat", 64'(rsp_sat), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        mq.delete();
        mptr = 0;
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        @(negedge clk);
        cyc++;
        rst       = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("init_req_ready", 64'(req_ready), 64'(0));
        chk("init_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("init_rsp_data", 64'(rsp_data), 64'(0));
        chk("init_busy", 64'(busy), 64'(0));
        rst       = 1'b0;
        req_valid = '0;

        // Both requesters continuously valid: strict alternation from 01.
        for (int i = 0; i < 4; i++) begin
            refill(1'b1);
            step(1'b0);
            chk("alt_grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        repeat (LAT) step(1'b0);

        single(0, 32'h00018000, 32'h00020000, 32'h00030000, 1'b0);
        single(1, 32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b1);
        single(0, 32'h80000000, 32'h00020000, 32'h80000000, 1'b1);
        single(1, 32'h00000001, 32'h00008000, 32'h00000001, 1'b0);
        single(0, 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b0);

        // Flush with three ops in flight from requester 0.
        for (int i = 0; i < 3; i++) begin
            pend_v[0] = 1'b1;
            pend_a[0] = rnd_op();
            pend_b[0] = rnd_op();
            step(1'b0);
        end
        pend_v[0] = 1'b1;
        step(1'b1);
        chk("flush_out_stage", 64'(rsp_valid), 64'h1);
        pend_v[0] = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("flush_busy", 64'(busy), 64'(0));
        refill(1'b1);
        step(1'b0);
        chk("flush_ptr_kept", 64'(req_ready), 64'h2);

        for (int c = 0; c < 300; c++) begin
            refill(1'b0);
            step($urandom_range(0, 19) == 0);
        end

        do_reset();
        refill(1'b1);
        step(1'b0);
        chk("first_grant_after_rst", 64'(req_ready), 64'h1);

        for (int c = 0; c < 300; c++) begin
            refill(1'b0);
            step($urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        repeat (LAT + 1) step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and pipelined signed fixed-point multiplier shared by the linear-regression gradient datapaths (theta_0 path, theta_1 path, optional extra requesters). Each requester presents operand pairs with a valid/ready handshake. The block grants at most one pair per cycle, multiplies it in a fixed-latency pipeline, and returns the rounded, saturated product to the originating requester tagged by a one-hot valid. It sits between the per-theta datapaths and the single DSP multiplier budgeted for the design, and replaces per-path multipliers.

## Interface
- DW, 32: operand/result width, signed two's complement.
- FRAC, 16: fractional bits (Q(DW-FRAC).FRAC format for operands and result).
- N_REQ, 2: number of requesters, legal range 2..4.
- MUL_LAT, 3: cycles from acceptance to response, legal range 1..6.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline clear, drops all in-flight operations.
- req_valid  in  N_REQ  per-requester operand pair valid.
- req_a  in  N_REQ*DW  operand A, requester i at bits [i*DW +: DW].
- req_b  in  N_REQ*DW  operand B, same packing.
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  N_REQ  one-hot, marks which requester owns rsp_data this cycle.
- rsp_data  out  DW  product result.
- rsp_sat  out  1  result was clamped; valid only with rsp_valid.
- busy  out  1  at least one operation in flight.

## Operation
- Arbitration is round-robin. Pointer ptr (0..N_REQ-1) holds the highest-priority index. The granted requester is the first i with req_valid[i], searching ptr, ptr+1, … mod N_REQ.
- After a transfer to requester g, ptr becomes (g+1) mod N_REQ. With no transfer, ptr holds.
- req_ready is combinational from req_valid and ptr. At most one bit is set. Ready is never asserted to a requester whose valid is low.
- Requesters hold req_valid, req_a and req_b stable until their transfer. Deasserting valid before the transfer is allowed and simply withdraws the request.
- Product: full 2*DW signed product, rounded by adding 1<<(FRAC-1), then arithmetically shifted right by FRAC.
- If the shifted value exceeds the signed DW range, rsp_data clamps to 2^(DW-1)-1 or -2^(DW-1), and rsp_sat=1.
- Responses have no backpressure. Consumers must accept rsp_valid in the cycle it is high.
- flush=1 clears all pipeline valid/tag bits at the next edge. No rsp_valid is produced for dropped ops. During a flush cycle req_ready is 0 and ptr holds.
- busy = OR of all pipeline stage valid bits.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_sat=0, busy=0, ptr=0, all pipeline valids=0.
- req_ready is forced to 0 while rst is high.
- Throughput is one transfer per cycle, sustained.
- Latency: a transfer sampled at edge t drives rsp_valid, rsp_data and rsp_sat in the cycle after edge t+MUL_LAT-1, i.e. MUL_LAT cycles later. All three are registered outputs.
- Responses appear in acceptance order, with the one-hot tag carried alongside the data.
- busy rises the cycle after the first transfer. It falls the cycle after the last response, or the cycle after a flush.
- Simultaneous requests from all requesters give grants in strict rotation i, i+1, … with no requester waiting more than N_REQ-1 cycles.
- rst asserted mid-operation discards in-flight ops immediately (asynchronously); no responses are emitted for them.
- flush and a response due in the same cycle: the response that is already registered in the output stage is still presented this cycle. Nothing upstream of it survives.

## Structure
- Shared package lr_pkg holds:
  - Q-format constants (DW, FRAC).
  - Saturation limit constants.
  - Requester index constants (REQ_THETA0=0, REQ_THETA1=1).
- Sub-module mul_pipe: signed multiply, round, shift and saturate across MUL_LAT register stages, with a valid+tag shift register in parallel.
- The arbiter logic (ptr, grant search) lives in mul_share_arb itself.

## Test plan
- Single request: requester 0 sends a=0x00018000 (1.5), b=0x00020000 (2.0) → after 3 cycles rsp_valid=01, rsp_data=0x00030000, rsp_sat=0.
- Both requesters valid continuously from reset → grants alternate 01,10,01,10 starting with 01. Responses return in the same order, each 3 cycles after its grant.
- Saturation: a=0x7FFF0000, b=0x00020000 → rsp_data=0x7FFFFFFF, rsp_sat=1. a=0x80000000, b=0x00020000 → rsp_data=0x80000000, rsp_sat=1.
- Rounding: a=0x00000001, b=0x00008000 → rsp_data=0x00000001. A negative product of -0.5 LSB, e.g. a=0xFFFFFFFF, b=0x00008000 → rsp_data=0x00000000.
- Flush with 3 ops in flight → at most the op already in the output stage is presented. busy=0 two cycles later, and ptr is unchanged.
- rst asserted for 1 cycle mid-stream → all outputs go to their reset values immediately. No stale rsp_valid appears after release, and the first grant after reset goes to requester 0.
